// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_ctrl
// Purpose  : Presents a single-port synchronous SRAM as an in-order FIFO of
//            DEPTH words, followed by a 2-entry output buffer. Total capacity
//            is DEPTH+2 words.
//            At most one SRAM access is made per cycle. When both a write and
//            a read are eligible, they take turns.
// Ports    : CLK, RESET_N (async, active-low)
//            in_valid/in_ready/in_data     - upstream valid/ready stream
//            out_valid/out_ready/out_data  - downstream valid/ready stream
//            CEN, WEN, A, D                - SRAM command (combinational)
//            Q                             - SRAM read data, valid one
//                                            cycle after the read edge
//            level, max_level              - occupancy and high-water mark,
//                                            present only when the macro
//                                            SRAM_FIFO_CTRL_STATUS_EN is
//                                            defined
// Revision : 1.0 - initial release
// ============================================================================
module sram_fifo_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
`ifdef SRAM_FIFO_CTRL_STATUS_EN
  ,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W:0]   max_level
`endif
);

  localparam int                CW         = ADDR_W + 1;
  localparam logic [CW-1:0]     C_DEPTH    = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] C_PTR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     sram_cnt_q, sram_cnt_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              rif_q, rif_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;

  logic              wr_elig;
  logic              rd_elig;
  logic              wr_gnt;
  logic              rd_gnt;
  logic              pop;
  logic [1:0]        buf_occ;

  // Slots already promised to the output buffer: words held and a read whose
  // data has not yet returned.
  assign buf_occ = buf_cnt_q + {1'b0, rif_q};

  // Gating with RESET_N keeps the SRAM idle and in_ready low while reset is
  // asserted, even if in_valid is high.
  assign wr_elig = RESET_N & in_valid & (sram_cnt_q < C_DEPTH);
  assign rd_elig = RESET_N & (sram_cnt_q != '0) & (buf_occ < 2'd2);

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (wr_elig && rd_elig) begin
      // Contended: alternate with respect to the previous grant.
      wr_gnt = (last_grant_q == GNT_RD);
      rd_gnt = (last_grant_q == GNT_WR);
    end else begin
      wr_gnt = wr_elig;
      rd_gnt = rd_elig;
    end
  end

  // SRAM command; A and D hold their previous values while idle.
  assign in_ready = wr_gnt;
  assign CEN      = ~(wr_gnt | rd_gnt);
  assign WEN      = ~wr_gnt;
  assign A        = wr_gnt ? wr_ptr_q : (rd_gnt ? rd_ptr_q : a_q);
  assign D        = wr_gnt ? in_data : d_q;

  assign out_valid = (buf_cnt_q != 2'd0);
  assign out_data  = buf0_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    sram_cnt_d   = sram_cnt_q;
    last_grant_d = last_grant_q;
    rif_d        = rd_gnt;
    if (wr_gnt) begin
      wr_ptr_d     = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + ADDR_W'(1);
      sram_cnt_d   = sram_cnt_q + CW'(1);
      last_grant_d = GNT_WR;
    end else if (rd_gnt) begin
      rd_ptr_d     = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + ADDR_W'(1);
      sram_cnt_d   = sram_cnt_q - CW'(1);
      last_grant_d = GNT_RD;
    end
  end

  // Output buffer: buf0 is always the head. Read data arriving in the cycle
  // after a read edge is appended; a simultaneous pop shifts first so order
  // is preserved. The read eligibility rule guarantees room for the capture.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({rif_q, pop})
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b10: begin
        if (buf_cnt_q == 2'd0) begin
          buf0_d = Q;
        end else begin
          buf1_d = Q;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = Q;
        end else begin
          buf0_d = buf1_q;
          buf1_d = Q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sram_cnt_q   <= '0;
      buf_cnt_q    <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      rif_q        <= 1'b0;
      last_grant_q <= GNT_RD;
      a_q          <= '0;
      d_q          <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sram_cnt_q   <= sram_cnt_d;
      buf_cnt_q    <= buf_cnt_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      rif_q        <= rif_d;
      last_grant_q <= last_grant_d;
      a_q          <= A;
      d_q          <= D;
    end
  end

`ifdef SRAM_FIFO_CTRL_STATUS_EN
  logic [CW-1:0] level_d;
  logic [CW-1:0] max_level_q;

  assign level   = sram_cnt_q + CW'(buf_cnt_q) + CW'(rif_q);
  assign level_d = sram_cnt_d + CW'(buf_cnt_d) + CW'(rif_d);

  // Tracks the next level so the mark already covers the current level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      max_level_q <= '0;
    end else if (level_d > max_level_q) begin
      max_level_q <= level_d;
    end
  end

  assign max_level = max_level_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_fifo_ctrl
// Purpose  : Self-checking bench for sram_fifo_ctrl with a behavioural SRAM
//            and a queue-based reference model of the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_fifo_ctrl;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;

  logic              CLK;
  logic              RESET_N;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              CEN;
  logic              WEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;
`ifdef SRAM_FIFO_CTRL_STATUS_EN
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   max_level;
`endif

  sram_fifo_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .CEN       (CEN),
    .WEN       (WEN),
    .A         (A),
    .D         (D),
    .Q         (Q)
`ifdef SRAM_FIFO_CTRL_STATUS_EN
    ,
    .level     (level),
    .max_level (max_level)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural single-port synchronous SRAM.
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q      <= mem[A];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: words resident in the SRAM as a queue, output buffer as
  // a queue, plus the word whose read is in flight.
  int                m_cnt, m_wr, m_rd, m_max;
  bit                m_rif, m_last_rd;
  logic [63:0]       m_sq[$];
  logic [63:0]       m_buf[$];
  logic [63:0]       m_pend;
  logic [ADDR_W-1:0] m_last_a;
  logic [63:0]       m_last_d;

  // Observations taken by the last cycle() call.
  bit                o_wr, o_rd, o_pop;
  logic [ADDR_W-1:0] o_a;
  logic [63:0]       o_out;

  task automatic model_reset();
    m_cnt = 0; m_wr = 0; m_rd = 0; m_max = 0;
    m_rif = 0; m_last_rd = 1;
    m_sq.delete(); m_buf.delete();
    m_pend = '0; m_last_a = '0; m_last_d = '0;
  endtask

  task automatic model_step(input logic iv, input logic [63:0] id, input logic ordy);
    bit we, re, gw, gr, ev;
    int lvl;
    we = iv && (m_cnt < DEPTH);
    re = (m_cnt > 0) && ((m_buf.size() + int'(m_rif)) < 2);
    if (we && re) begin
      gw = m_last_rd;
      gr = !m_last_rd;
    end else begin
      gw = we;
      gr = re;
    end
    if (gw) begin
      m_last_a = ADDR_W'(m_wr);
      m_last_d = id;
    end else if (gr) begin
      m_last_a = ADDR_W'(m_rd);
    end
    ev = (m_buf.size() > 0);
    chk("in_ready", in_ready, gw);
    chk("CEN", CEN, !(gw || gr));
    chk("WEN", WEN, !gw);
    chk("A", A, m_last_a);
    chk("D", D, m_last_d);
    chk("out_valid", out_valid, ev);
    if (ev) chk("out_data", out_data, m_buf[0]);
`ifdef SRAM_FIFO_CTRL_STATUS_EN
    lvl = m_cnt + m_buf.size() + int'(m_rif);
    if (lvl > m_max) m_max = lvl;
    chk("level", level, lvl);
    chk("max_level", max_level, m_max);
`else
    lvl = 0;
`endif
    // Effects of the coming rising edge.
    if (ev && ordy) void'(m_buf.pop_front());
    if (m_rif) m_buf.push_back(m_pend);
    m_rif = 0;
    if (gr) begin
      m_pend = m_sq.pop_front();
      m_rif  = 1;
      m_rd   = (m_rd + 1) % DEPTH;
      m_cnt--;
      m_last_rd = 1;
    end
    if (gw) begin
      m_sq.push_back(id);
      m_wr = (m_wr + 1) % DEPTH;
      m_cnt++;
      m_last_rd = 0;
    end
  endtask

  task automatic cycle(input logic iv, input logic [63:0] id, input logic ordy);
    @(negedge CLK);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    o_wr  = (in_ready === 1'b1);
    o_rd  = (CEN === 1'b0) && (WEN === 1'b1);
    o_pop = (out_valid === 1'b1) && ordy;
    o_a   = A;
    o_out = out_data;
    model_step(iv, id, ordy);
  endtask

  task automatic do_reset(input logic iv);
    @(negedge CLK);
    RESET_N   = 1'b0;
    in_valid  = iv;
    in_data   = '1;
    out_ready = 1'b1;
    #1;
    chk("rst_CEN", CEN, 1'b1);
    chk("rst_WEN", WEN, 1'b1);
    chk("rst_A", A, '0);
    chk("rst_D", D, '0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
`ifdef SRAM_FIFO_CTRL_STATUS_EN
    chk("rst_level", level, '0);
    chk("rst_max_level", max_level, '0);
`endif
    model_reset();
    @(negedge CLK);
    in_valid = 1'b0;
    RESET_N  = 1'b1;
  endtask

  logic [63:0] words[$];
  logic [63:0] got[$];
  logic [ADDR_W-1:0] waddr[$];
  int acc, wr_cnt;
  bit prev_wr;

  initial begin
    RESET_N   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset with in_valid high, then idle after release.
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);

    // Single word latency.
    cycle(1'b1, 64'h0123456789ABCDEF, 1'b1);
    chk("lat_e1_write", {o_wr, o_a}, {1'b1, 4'd0});
    cycle(1'b0, '0, 1'b1);
    chk("lat_e2_read", {o_rd, o_a}, {1'b1, 4'd0});
    cycle(1'b0, '0, 1'b1);
    chk("lat_e3_no_valid_yet", out_valid, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("lat_out", {o_pop, o_out}, {1'b1, 64'h0123456789ABCDEF});
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1);

    // Capacity: 12 words offered with the output stalled.
    words.delete();
    for (int i = 0; i < 12; i++) words.push_back({32'hC0DE0000 + i, $urandom()});
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, words[acc], 1'b0);
      if (o_wr && acc < 11) acc++;
    end
    chk("cap_accepted", acc, 10);
    chk("cap_in_ready_low", in_ready, 1'b0);
    got.delete();
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (o_pop) got.push_back(o_out);
    end
    chk("cap_drain_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("cap_drain_order", got[i], words[i]);

    // Stream of 20 words from fresh pointers.
    do_reset(1'b0);
    words.delete(); got.delete(); waddr.delete();
    for (int i = 0; i < 20; i++) words.push_back({$urandom(), $urandom()});
    acc = 0;
    for (int i = 0; i < 80; i++) begin
      if (acc < 20) cycle(1'b1, words[acc], 1'b1);
      else          cycle(1'b0, '0, 1'b1);
      if (o_wr) begin
        waddr.push_back(o_a);
        acc++;
      end
      if (o_pop) got.push_back(o_out);
    end
    chk("stream_write_count", waddr.size(), 20);
    for (int i = 0; i < 20 && i < waddr.size(); i++) chk("stream_addr", waddr[i], i % 8);
    chk("stream_out_count", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("stream_order", got[i], words[i]);

    // Steady state: grants alternate every cycle.
    wr_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, {$urandom(), $urandom()}, 1'b1);
      if (i >= 10) begin
        chk("alt_granted", o_wr || o_rd, 1'b1);
        chk("alt_switch", o_wr != prev_wr, 1'b1);
        if (o_wr) wr_cnt++;
      end
      prev_wr = o_wr;
    end
    chk("alt_wr_count", wr_cnt, 15);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, $urandom_range(0, 9) < 6);
    for (int i = 0; i < 30; i++) cycle(1'b0, '0, 1'b1);

    // Reset in the cycle after a read edge.
    do_reset(1'b0);
    cycle(1'b1, 64'hDEADBEEFCAFEF00D, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("mid_read_issued", o_rd, 1'b1);
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("mid_no_valid", out_valid, 1'b0);
      chk("mid_sram_idle", CEN, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
